// File: rtl/spi_transfer_controller.sv
// Sequences one 8-bit SPI mode-0, MSB-first transfer through an external shift_register:
// load, chip select, SCLK generation, one shift strobe per bit, then read-back of the received byte.
module spi_transfer_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rx_data,
  output logic       o_sclk,
  output logic       o_cs_n,
  input  logic       i_miso,
  output logic [1:0] o_sr_mode,
  output logic       o_sr_output_enable_n,
  output logic       o_sr_slow_clk,
  output logic [7:0] o_sr_parallel,
  output logic       o_sr_serial,
  input  logic [7:0] i_sr_parallel
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 8;
  localparam int unsigned DATA_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_XFER,
    S_READ,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic [1:0]          sr_mode_q, sr_mode_d;
  logic                sr_oe_n_q, sr_oe_n_d;
  logic                sr_slow_clk_q, sr_slow_clk_d;
  logic [DATA_W-1:0]   sr_parallel_q, sr_parallel_d;
  logic                sr_serial_q, sr_serial_d;
  logic                div_last;
  logic                sclk_nxt;

  assign div_last = (div_cnt_q == DIV_LAST);

  // Next state plus the registered outputs for the cycle that state_d describes.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    sclk_nxt      = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    cs_n_d        = 1'b1;
    sclk_d        = 1'b0;
    sr_mode_d     = 2'b00;
    sr_oe_n_d     = 1'b1;
    sr_slow_clk_d = 1'b0;
    rx_data_d     = rx_data_q;
    sr_parallel_d = sr_parallel_q;
    sr_serial_d   = sr_serial_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d       = S_LOAD;
          sr_parallel_d = i_tx_data;
        end
      end
      S_LOAD: begin
        state_d   = S_SETUP;
        div_cnt_d = '0;
      end
      S_SETUP: begin
        if (div_last) begin
          state_d   = S_XFER;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_XFER: begin
        sclk_nxt = sclk_q;
        if (div_last) begin
          div_cnt_d = '0;
          sclk_nxt  = ~sclk_q;
          if (sclk_q) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d  = S_READ;
              sclk_nxt = 1'b0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_LOAD: begin
        busy_d    = 1'b1;
        sr_mode_d = 2'b11;
      end
      S_SETUP: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
      end
      S_XFER: begin
        busy_d        = 1'b1;
        cs_n_d        = 1'b0;
        sr_mode_d     = 2'b10;
        sclk_d        = sclk_nxt;
        sr_slow_clk_d = sclk_nxt && (div_cnt_d == DIV_LAST);
        if (sclk_nxt && !sclk_q) begin
          sr_serial_d = i_miso;
        end
      end
      S_READ: begin
        busy_d    = 1'b1;
        cs_n_d    = 1'b0;
        sr_oe_n_d = 1'b0;
      end
      S_CAPTURE: begin
        // Sampled while READ has the register's output enabled.
        busy_d    = 1'b1;
        cs_n_d    = 1'b0;
        rx_data_d = i_sr_parallel;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_data_q     <= '0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      sr_mode_q     <= 2'b00;
      sr_oe_n_q     <= 1'b1;
      sr_slow_clk_q <= 1'b0;
      sr_parallel_q <= '0;
      sr_serial_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rx_data_q     <= rx_data_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      sr_mode_q     <= sr_mode_d;
      sr_oe_n_q     <= sr_oe_n_d;
      sr_slow_clk_q <= sr_slow_clk_d;
      sr_parallel_q <= sr_parallel_d;
      sr_serial_q   <= sr_serial_d;
    end
  end

  assign o_busy               = busy_q;
  assign o_done               = done_q;
  assign o_rx_data            = rx_data_q;
  assign o_sclk               = sclk_q;
  assign o_cs_n               = cs_n_q;
  assign o_sr_mode            = sr_mode_q;
  assign o_sr_output_enable_n = sr_oe_n_q;
  assign o_sr_slow_clk        = sr_slow_clk_q;
  assign o_sr_parallel        = sr_parallel_q;
  assign o_sr_serial          = sr_serial_q;

endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench: two controllers (CLK_DIV=2 and CLK_DIV=1), each wired to a small shift_register
// model, with loopback or a mode-0 slave returning a fixed byte on MISO.
module tb_spi_transfer_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic rst;

  // Instance A: CLK_DIV=2
  logic       a_start, a_busy, a_done, a_sclk, a_cs_n, a_miso, a_oe_n, a_slow, a_ser;
  logic [7:0] a_tx, a_rx, a_par_out, a_par_in, a_q;
  logic [1:0] a_mode;
  logic       a_loop;
  logic [7:0] a_slave_byte;
  logic       a_slave_bit;

  spi_transfer_controller #(.CLK_DIV(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_tx_data(a_tx),
    .o_busy(a_busy), .o_done(a_done), .o_rx_data(a_rx), .o_sclk(a_sclk), .o_cs_n(a_cs_n),
    .i_miso(a_miso), .o_sr_mode(a_mode), .o_sr_output_enable_n(a_oe_n),
    .o_sr_slow_clk(a_slow), .o_sr_parallel(a_par_out), .o_sr_serial(a_ser),
    .i_sr_parallel(a_par_in)
  );

  always_ff @(posedge clk) begin
    if (rst) a_q <= 8'h00;
    else if (a_mode == 2'b11) a_q <= a_par_out;
    else if (a_mode == 2'b10 && a_slow) a_q <= {a_q[6:0], a_ser};
  end
  assign a_par_in = a_oe_n ? 8'h00 : a_q;

  int         a_rises = 0, a_strobes = 0, a_cs_low = 0, a_dones = 0;
  logic [7:0] a_mosi_bits = 8'h00;
  logic       a_sclk_prev = 1'b0;

  assign a_slave_bit = (a_rises < 8) ? a_slave_byte[3'(7 - a_rises)] : 1'b0;
  assign a_miso      = a_loop ? a_q[7] : a_slave_bit;

  always @(negedge clk) begin
    if (a_mode == 2'b11) begin
      a_rises = 0; a_strobes = 0; a_cs_low = 0; a_mosi_bits = 8'h00;
    end
    if (a_sclk && !a_sclk_prev) begin
      a_rises++;
      a_mosi_bits = {a_mosi_bits[6:0], a_q[7]};
    end
    if (a_slow) a_strobes++;
    if (!a_cs_n) a_cs_low++;
    if (a_done) a_dones++;
    a_sclk_prev = a_sclk;
  end

  // Instance B: CLK_DIV=1, loopback only
  logic       b_start, b_busy, b_done, b_sclk, b_cs_n, b_oe_n, b_slow, b_ser;
  logic [7:0] b_tx, b_rx, b_par_out, b_par_in, b_q;
  logic [1:0] b_mode;

  spi_transfer_controller #(.CLK_DIV(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_tx_data(b_tx),
    .o_busy(b_busy), .o_done(b_done), .o_rx_data(b_rx), .o_sclk(b_sclk), .o_cs_n(b_cs_n),
    .i_miso(b_q[7]), .o_sr_mode(b_mode), .o_sr_output_enable_n(b_oe_n),
    .o_sr_slow_clk(b_slow), .o_sr_parallel(b_par_out), .o_sr_serial(b_ser),
    .i_sr_parallel(b_par_in)
  );

  always_ff @(posedge clk) begin
    if (rst) b_q <= 8'h00;
    else if (b_mode == 2'b11) b_q <= b_par_out;
    else if (b_mode == 2'b10 && b_slow) b_q <= {b_q[6:0], b_ser};
  end
  assign b_par_in = b_oe_n ? 8'h00 : b_q;

  // Start a transfer on A; optionally re-pulse i_start with 8'h00 at cycle 'poke'.
  task automatic a_xfer(input logic [7:0] tx, input int poke, output int done_cyc);
    done_cyc = -1;
    a_tx     = tx;
    a_start  = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == poke) begin
        a_start = 1'b1;
        a_tx    = 8'h00;
      end else if (k == poke + 1) begin
        a_start = 1'b0;
      end
      if (a_done) begin
        done_cyc = k;
        break;
      end
      tick();
    end
    a_start = 1'b0;
  endtask

  int dc, d0, first, second, busy_low;
  logic [7:0] rx1, rx2;

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_tx = 8'h00; a_loop = 1'b1; a_slave_byte = 8'h00;
    b_start = 1'b0; b_tx = 8'h00;
    repeat (16) tick();
    rst = 1'b0;
    tick();

    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_done", a_done, 1'b0);
    check_eq("rst_rx", a_rx, 8'h00);
    check_eq("rst_sclk", a_sclk, 1'b0);
    check_eq("rst_cs_n", a_cs_n, 1'b1);
    check_eq("rst_mode", a_mode, 2'b00);
    check_eq("rst_oe_n", a_oe_n, 1'b1);
    check_eq("rst_slow", a_slow, 1'b0);
    check_eq("rst_par", a_par_out, 8'h00);
    check_eq("rst_ser", a_ser, 1'b0);
    check_eq("rst_b_cs_n", b_cs_n, 1'b1);

    // Loopback A5
    a_loop = 1'b1;
    a_xfer(8'hA5, 0, dc);
    check_eq("a5_done_cyc", dc, 38);
    repeat (3) tick();
    check_eq("a5_rx", a_rx, 8'hA5);
    check_eq("a5_rises", a_rises, 8);
    check_eq("a5_strobes", a_strobes, 8);
    check_eq("a5_cs_low", a_cs_low, 36);
    check_eq("a5_busy_end", a_busy, 1'b0);
    check_eq("a5_cs_end", a_cs_n, 1'b1);

    // Slave returns 3C while C3 is sent
    a_loop = 1'b0;
    a_slave_byte = 8'h3C;
    a_xfer(8'hC3, 0, dc);
    repeat (3) tick();
    check_eq("slave_rx", a_rx, 8'h3C);
    check_eq("slave_mosi", a_mosi_bits, 8'hC3);

    // Second request during XFER is ignored
    a_loop = 1'b1;
    d0 = a_dones;
    a_xfer(8'h96, 10, dc);
    repeat (60) tick();
    check_eq("ign_done_cyc", dc, 38);
    check_eq("ign_done_cnt", a_dones - d0, 1);
    check_eq("ign_rx", a_rx, 8'h96);

    // Reset after the 3rd SCLK rise
    d0 = a_dones;
    a_tx = 8'h77;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 200 && a_rises != 3; k++) tick();
    check_eq("mid_rises", a_rises, 3);
    rst = 1'b1;
    tick();
    check_eq("mid_cs_n", a_cs_n, 1'b1);
    check_eq("mid_sclk", a_sclk, 1'b0);
    check_eq("mid_busy", a_busy, 1'b0);
    check_eq("mid_mode", a_mode, 2'b00);
    rst = 1'b0;
    repeat (60) tick();
    check_eq("mid_no_done", a_dones - d0, 0);
    check_eq("mid_rx", a_rx, 8'h00);
    a_xfer(8'h5A, 0, dc);
    repeat (3) tick();
    check_eq("post_done_cyc", dc, 38);
    check_eq("post_rx", a_rx, 8'h5A);

    // CLK_DIV=1, start held high: FF then 01
    b_tx = 8'hFF;
    b_start = 1'b1;
    tick();
    first = -1; second = -1; busy_low = 0; rx1 = 8'h00; rx2 = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      if (k == 5) b_tx = 8'h01;
      if (b_done) begin
        if (first < 0) begin
          first = k; rx1 = b_rx;
        end else if (second < 0) begin
          second = k; rx2 = b_rx; b_start = 1'b0;
        end
      end
      if (first >= 0 && second < 0 && !b_busy) busy_low++;
      tick();
    end
    b_start = 1'b0;
    check_eq("div1_done1", first, 21);
    check_eq("div1_done2", second, 43);
    check_eq("div1_busy_gap", busy_low, 1);
    check_eq("div1_rx1", rx1, 8'hFF);
    check_eq("div1_rx2", rx2, 8'h01);
    check_eq("div1_idle", b_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
